// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus blocks (reader and writer).
// Bus timing is kept in ns and converted to clock cycles by each block.
package lcd_pkg;

    localparam int T_AS_NS = 60;
    localparam int T_PW_NS = 450;
    localparam int T_EL_NS = 550;

    localparam int LCD_BF_BIT = 7;
    localparam int LCD_AC_MSB = 6;
    localparam int LCD_AC_LSB = 0;

    localparam logic LCD_RS_INSTR = 1'b0;
    localparam logic LCD_RS_DATA  = 1'b1;

    localparam int PHASE_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_E_HIGH,
        ST_E_LOW,
        ST_DONE
    } rd_state_t;

    // Rounds up so a bus minimum is never violated at odd clock rates.
    function automatic int cycles_from_ns(input longint clk_hz, input longint ns);
        longint num;
        longint den;
        den = 64'sd1_000_000_000;
        num = clk_hz * ns + den - 64'sd1;
        return int'(num / den);
    endfunction

endpackage

// File: rtl/lcd_strobe_timer.sv
// Phase counter for LCD bus strobes: counts 0..len-1 and flags the last cycle.
// A clear restarts the count at 0 on the following cycle.
module lcd_strobe_timer
    import lcd_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic [PHASE_W-1:0] len,
    output logic               last
);

    logic [PHASE_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == len - 1'b1);

endmodule

// File: rtl/lcd_reader.sv
// Read-cycle engine for the 8-bit LCD bus: status/data reads and busy-flag polling.
// All pin outputs are registered from the next state so E and RS/RW are glitch-free.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | bus released, waiting for req
// SETUP   | RS/RW driven, E low for T_AS cycles
// E_HIGH  | E high for T_PW cycles, d_in sampled on the last cycle
// E_LOW   | E low for T_EL cycles, then repeat poll or finish
// DONE    | one-cycle rsp_valid, bus released
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int T_AS      = cycles_from_ns(CLK_FREQ, T_AS_NS),
    parameter int T_PW      = cycles_from_ns(CLK_FREQ, T_PW_NS),
    parameter int T_EL      = cycles_from_ns(CLK_FREQ, T_EL_NS),
    parameter int MAX_POLLS = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req,
    input  logic       req_rs,
    input  logic       req_poll,
    output logic       busy,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       bus_own,
    output logic       rs,
    output logic       rw,
    output logic       e,
    input  logic [7:0] d_in
);

    rd_state_t          state;
    rd_state_t          state_next;
    logic               rs_sel;
    logic               rs_sel_next;
    logic               poll_mode;
    logic               poll_mode_next;
    logic [7:0]         poll_cnt;
    logic [7:0]         poll_cnt_next;
    logic [7:0]         data_next;
    logic [PHASE_W-1:0] phase_len;
    logic               phase_last;
    logic               tmr_clear;
    logic               active_next;

    lcd_strobe_timer u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (tmr_clear),
        .len     (phase_len),
        .last    (phase_last)
    );

    always_comb begin
        state_next     = state;
        phase_len      = '0;
        rs_sel_next    = rs_sel;
        poll_mode_next = poll_mode;
        poll_cnt_next  = poll_cnt;
        data_next      = rsp_data;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    rs_sel_next    = req_rs;
                    poll_mode_next = req_poll & ~req_rs;
                    poll_cnt_next  = 8'(MAX_POLLS);
                    state_next     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                phase_len = PHASE_W'(T_AS);
                if (phase_last) state_next = ST_E_HIGH;
            end
            ST_E_HIGH: begin
                phase_len = PHASE_W'(T_PW);
                if (phase_last) begin
                    data_next     = d_in;
                    poll_cnt_next = poll_cnt - 8'd1;
                    state_next    = ST_E_LOW;
                end
            end
            ST_E_LOW: begin
                phase_len = PHASE_W'(T_EL);
                if (phase_last) begin
                    // rsp_data already holds this strobe's byte, so BF is current here
                    if (poll_mode && rsp_data[LCD_BF_BIT] && (poll_cnt != 8'd0))
                        state_next = ST_SETUP;
                    else
                        state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign tmr_clear   = (state_next != state) || (state == ST_IDLE);
    assign active_next = (state_next == ST_SETUP) || (state_next == ST_E_HIGH) ||
                         (state_next == ST_E_LOW);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            rs_sel      <= LCD_RS_INSTR;
            poll_mode   <= 1'b0;
            poll_cnt    <= '0;
            rsp_data    <= '0;
            busy        <= 1'b0;
            bus_own     <= 1'b0;
            rw          <= 1'b0;
            rs          <= 1'b0;
            e           <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            rs_sel      <= rs_sel_next;
            poll_mode   <= poll_mode_next;
            poll_cnt    <= poll_cnt_next;
            rsp_data    <= data_next;
            busy        <= active_next;
            bus_own     <= active_next;
            rw          <= active_next;
            rs          <= active_next ? rs_sel_next : LCD_RS_INSTR;
            e           <= (state_next == ST_E_HIGH);
            rsp_valid   <= (state_next == ST_DONE);
            rsp_timeout <= (state_next == ST_DONE) && poll_mode && rsp_data[LCD_BF_BIT];
        end
    end

endmodule

// File: tb/tb_lcd_reader.sv
// Bench for lcd_reader: scoreboard of expected responses checked against observed ones.
module tb_lcd_reader;

    localparam int T_AS = 6;
    localparam int T_PW = 45;
    localparam int T_EL = 55;
    localparam int STROBE = T_AS + T_PW + T_EL;
    localparam int LAT = 1 + STROBE;

    typedef struct {
        logic [7:0] data;
        logic       timeout;
        int         cyc;
    } rsp_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       req, req_rs, req_poll;
    logic [7:0] d_in;
    logic       busy, rsp_valid, rsp_timeout, bus_own, rs, rw, e;
    logic [7:0] rsp_data;

    logic       req4, req_rs4, req_poll4;
    logic [7:0] d_in4;
    logic       busy4, rsp_valid4, rsp_timeout4, bus_own4, rs4, rw4, e4;
    logic [7:0] rsp_data4;

    always #5 clock = ~clock;

    lcd_reader dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_rs(req_rs), .req_poll(req_poll),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .bus_own(bus_own), .rs(rs), .rw(rw), .e(e), .d_in(d_in)
    );

    lcd_reader #(.MAX_POLLS(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .req(req4), .req_rs(req_rs4), .req_poll(req_poll4),
        .busy(busy4), .rsp_valid(rsp_valid4), .rsp_data(rsp_data4), .rsp_timeout(rsp_timeout4),
        .bus_own(bus_own4), .rs(rs4), .rw(rw4), .e(e4), .d_in(d_in4)
    );

    int   errors = 0;
    int   checks = 0;
    int   edge_cnt = 0;
    rsp_t sb[$];
    rsp_t obs[$];
    rsp_t obs4[$];
    int   rd_idx = 0;
    int   rd_idx4 = 0;

    int   pulses = 0, pulses4 = 0;
    int   rise_abs = 0, last_pw = 0;
    logic rs_at_rise = 1'b0;
    logic e_prev = 1'b0, e4_prev = 1'b0;
    int   ctl_bad = 0;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    always @(negedge clock) begin
        if (rsp_valid) obs.push_back('{rsp_data, rsp_timeout, edge_cnt});
        if (rsp_valid4) obs4.push_back('{rsp_data4, rsp_timeout4, edge_cnt});
        if (e && !e_prev) begin
            pulses     = pulses + 1;
            rise_abs   = edge_cnt;
            rs_at_rise = rs;
        end
        if (!e && e_prev) last_pw = edge_cnt - rise_abs;
        if (e && ((rs !== rs_at_rise) || (rw !== 1'b1) || (bus_own !== 1'b1))) ctl_bad = ctl_bad + 1;
        if (e4 && !e4_prev) pulses4 = pulses4 + 1;
        e_prev  = e;
        e4_prev = e4;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Caller must be at a negedge; returns at the negedge of cycle 1.
    task automatic issue(input logic rsel, input logic poll, input bit push_exp,
                         input logic [7:0] xdata, input logic xto, input int xlat, output int t0);
        req_rs   = rsel;
        req_poll = poll;
        req      = 1'b1;
        t0       = edge_cnt;
        if (push_exp) sb.push_back('{xdata, xto, t0 + xlat});
        @(negedge clock);
        req = 1'b0;
    endtask

    task automatic pulse_at(input int tgt);
        while (edge_cnt < tgt) @(negedge clock);
        req = 1'b1;
        @(negedge clock);
        req = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, input string name, output bit ok, output rsp_t r);
        for (int i = 0; i < budget && rd_idx >= obs.size(); i++) @(negedge clock);
        ok = (rd_idx < obs.size());
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_arrival: no rsp_valid within %0d cycles", name, budget);
        end else begin
            r = obs[rd_idx];
            rd_idx++;
        end
    endtask

    task automatic check_rsp(input string name, input rsp_t r);
        rsp_t x;
        x = sb.pop_front();
        checks++;
        if (r.data !== x.data) begin
            errors++;
            $display("FAIL %s_data: got %02h expected %02h", name, r.data, x.data);
        end
        checks++;
        if (r.timeout !== x.timeout) begin
            errors++;
            $display("FAIL %s_timeout: got %0b expected %0b", name, r.timeout, x.timeout);
        end
        checks++;
        if (r.cyc !== x.cyc) begin
            errors++;
            $display("FAIL %s_latency: got cycle %0d expected %0d", name, r.cyc, x.cyc);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, rsp_valid, rsp_timeout, rsp_data, bus_own, rs, rw, e} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %015b expected all zero",
                     {busy, rsp_valid, rsp_timeout, rsp_data, bus_own, rs, rw, e});
        end
        checks++;
        if ({busy4, rsp_valid4, rsp_timeout4, rsp_data4, bus_own4, rs4, rw4, e4} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs4: got %015b expected all zero",
                     {busy4, rsp_valid4, rsp_timeout4, rsp_data4, bus_own4, rs4, rw4, e4});
        end
    endtask

    task automatic test_status_read;
        int t0, p0, b0;
        bit ok;
        rsp_t r;
        d_in = 8'h25;
        p0 = pulses;
        b0 = ctl_bad;
        issue(1'b0, 1'b0, 1'b1, 8'h25, 1'b0, LAT, t0);
        checks++;
        if ({busy, bus_own, rw, rs, e} !== 5'b11100) begin
            errors++;
            $display("FAIL status_cycle1_ctl: got %05b expected 11100", {busy, bus_own, rw, rs, e});
        end
        wait_rsp(400, "status", ok, r);
        if (ok) begin
            check_rsp("status", r);
            checks++;
            if (pulses - p0 !== 1) begin
                errors++;
                $display("FAIL status_pulses: got %0d expected 1", pulses - p0);
            end
            checks++;
            if (last_pw !== T_PW) begin
                errors++;
                $display("FAIL status_e_width: got %0d expected %0d", last_pw, T_PW);
            end
            checks++;
            if (rise_abs - t0 !== 1 + T_AS) begin
                errors++;
                $display("FAIL status_e_rise: got cycle %0d expected %0d", rise_abs - t0, 1 + T_AS);
            end
            checks++;
            if ({busy, bus_own, rw, rs} !== 4'b0000) begin
                errors++;
                $display("FAIL status_done_ctl: got %04b expected 0000", {busy, bus_own, rw, rs});
            end
            checks++;
            if (ctl_bad !== b0 || rs_at_rise !== 1'b0) begin
                errors++;
                $display("FAIL status_rs_rw: got bad=%0d rs=%0b expected bad=%0d rs=0",
                         ctl_bad, rs_at_rise, b0);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_data_read;
        int t0, p0;
        bit ok;
        rsp_t r;
        d_in = 8'h48;
        p0 = pulses;
        issue(1'b1, 1'b1, 1'b1, 8'h48, 1'b0, LAT, t0);
        wait_rsp(400, "data", ok, r);
        if (ok) begin
            check_rsp("data", r);
            checks++;
            if (pulses - p0 !== 1 || rs_at_rise !== 1'b1) begin
                errors++;
                $display("FAIL data_strobe: got pulses=%0d rs=%0b expected pulses=1 rs=1",
                         pulses - p0, rs_at_rise);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_poll_clears;
        int t0, p0;
        bit ok;
        d_in = 8'h80;
        p0 = pulses;
        issue(1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1 + 4 * STROBE, t0);
        for (int i = 0; i < 2000 && rd_idx >= obs.size(); i++) begin
            @(negedge clock);
            if (pulses - p0 >= 3 && !e) d_in = 8'h07;
        end
        checks++;
        ok = (rd_idx < obs.size());
        if (!ok) begin
            errors++;
            $display("FAIL poll_arrival: no rsp_valid within 2000 cycles");
        end else begin
            check_rsp("poll", obs[rd_idx]);
            rd_idx++;
            checks++;
            if (pulses - p0 !== 4) begin
                errors++;
                $display("FAIL poll_pulses: got %0d expected 4", pulses - p0);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_poll_timeout;
        int t0, p0;
        rsp_t r;
        d_in4     = 8'hFF;
        p0        = pulses4;
        req_rs4   = 1'b0;
        req_poll4 = 1'b1;
        req4      = 1'b1;
        t0        = edge_cnt;
        @(negedge clock);
        req4 = 1'b0;
        for (int i = 0; i < 2000 && rd_idx4 >= obs4.size(); i++) @(negedge clock);
        checks++;
        if (rd_idx4 >= obs4.size()) begin
            errors++;
            $display("FAIL poll_to_arrival: no rsp_valid within 2000 cycles");
        end else begin
            r = obs4[rd_idx4];
            rd_idx4++;
            checks++;
            if (r.data !== 8'hFF || r.timeout !== 1'b1) begin
                errors++;
                $display("FAIL poll_to_result: got data=%02h to=%0b expected data=ff to=1",
                         r.data, r.timeout);
            end
            checks++;
            if (pulses4 - p0 !== 4 || r.cyc - t0 !== 1 + 4 * STROBE) begin
                errors++;
                $display("FAIL poll_to_strobes: got pulses=%0d cycle=%0d expected 4 and %0d",
                         pulses4 - p0, r.cyc - t0, 1 + 4 * STROBE);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back;
        int t0, t1, p0;
        bit ok;
        rsp_t r;
        d_in = 8'h5A;
        p0 = pulses;
        issue(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, LAT, t0);
        pulse_at(t0 + 50);
        pulse_at(t0 + LAT);
        wait_rsp(10, "b2b_first", ok, r);
        if (ok) begin
            check_rsp("b2b_first", r);
            checks++;
            if (pulses - p0 !== 1) begin
                errors++;
                $display("FAIL b2b_extra_strobe: got %0d expected 1", pulses - p0);
            end
        end
        while (edge_cnt < t0 + LAT + 1) @(negedge clock);
        d_in = 8'hC3;
        issue(1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, LAT, t1);
        wait_rsp(400, "b2b_second", ok, r);
        if (ok) check_rsp("b2b_second", r);
        repeat (20) @(negedge clock);
        checks++;
        if (obs.size() !== rd_idx || pulses - p0 !== 2) begin
            errors++;
            $display("FAIL b2b_count: got rsp=%0d pulses=%0d expected rsp=%0d pulses=2",
                     obs.size(), pulses - p0, rd_idx);
        end
    endtask

    task automatic test_reset_mid_read;
        int t0, n0;
        bit ok;
        rsp_t r;
        d_in = 8'h11;
        issue(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, t0);
        for (int i = 0; i < 50 && !e; i++) @(negedge clock);
        n0 = obs.size();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({e, bus_own, busy, rsp_data} !== 11'd0) begin
            errors++;
            $display("FAIL reset_async: got e=%0b own=%0b busy=%0b data=%02h expected all 0",
                     e, bus_own, busy, rsp_data);
        end
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        repeat (200) @(negedge clock);
        checks++;
        if (obs.size() !== n0) begin
            errors++;
            $display("FAIL reset_no_rsp: got %0d responses expected %0d", obs.size(), n0);
        end
        d_in = 8'h3C;
        issue(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, LAT, t0);
        wait_rsp(400, "after_reset", ok, r);
        if (ok) check_rsp("after_reset", r);
        @(negedge clock);
    endtask

    initial begin
        reset_n   = 1'b0;
        req       = 1'b0;
        req_rs    = 1'b0;
        req_poll  = 1'b0;
        d_in      = 8'h00;
        req4      = 1'b0;
        req_rs4   = 1'b0;
        req_poll4 = 1'b0;
        d_in4     = 8'h00;
        repeat (3) @(negedge clock);
        test_reset();
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        test_status_read();
        test_data_read();
        test_poll_clears();
        test_poll_timeout();
        test_back_to_back();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_reader.md
# lcd_reader

Read-cycle engine for the HD44780-style 8-bit parallel LCD bus, the counterpart of the existing write-only LCD driver. It performs status reads (RS=0: busy flag plus address counter) and data-RAM reads (RS=1) with RW=1 and correctly timed E strobes. It can also poll the busy flag until it clears, so the controller can replace fixed post-command delays with real ready detection. It sits beside the LCD writer; the top level muxes RS/RW/E from whichever block asserts ownership and tristates the d pads while `bus_own`=1.

## Interface
- `CLK_FREQ`, 100000000: clock frequency in Hz.
- `T_AS`, 6: cycles RS/RW are stable before E rises (≥60 ns).
- `T_PW`, 45: cycles E is held high (≥450 ns); data is sampled on the last one.
- `T_EL`, 55: cycles E is held low after the strobe (E cycle ≥1000 ns).
- `MAX_POLLS`, 255: status reads per poll request before timeout (1..255).
- `clock` in 1: system clock. All logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in 1: start a read. Sampled only while `busy`=0.
- `req_rs` in 1: 0 selects a status read, 1 selects a data read. Captured with `req`.
- `req_poll` in 1: repeat status reads until BF=0. Ignored when `req_rs`=1.
- `busy` out 1: high from the cycle after an accepted `req` up to, but not including, the `rsp_valid` cycle.
- `rsp_valid` out 1: one-cycle pulse when the result is ready.
- `rsp_data` out 8: last sampled bus byte. Holds its value until the next sample.
- `rsp_timeout` out 1: qualified by `rsp_valid`. Set when a poll ended with BF still 1.
- `bus_own` out 1: reader owns RS/RW/E; the top level tristates the d pads.
- `rs` out 1, `rw` out 1, `e` out 1: LCD control pins.
- `d_in` in 8: LCD data pins, pad input path.

## Operation
- States are IDLE, SETUP, E_HIGH, E_LOW and DONE. A single phase counter (16 bits) counts 0..T-1 in each timed state and clears on every state change.
- IDLE: when `req`=1, capture `req_rs` and `req_poll & ~req_rs`, load the poll counter with MAX_POLLS, and go to SETUP. `bus_own`=1, `rw`=1, `rs`=captured value, `busy`=1.
- SETUP, T_AS cycles: `e`=0. Then go to E_HIGH.
- E_HIGH, T_PW cycles: `e`=1. On the last cycle, register `d_in` into `rsp_data` and decrement the poll counter. Then go to E_LOW.
- E_LOW, T_EL cycles: `e`=0, RW and RS unchanged. On exit:
  - If poll mode, `rsp_data[7]`=1 and the poll counter ≠0, go back to SETUP.
  - Otherwise go to DONE.
- DONE, one cycle: `rsp_valid`=1. `rsp_timeout`=poll mode & `rsp_data[7]`. `busy`=0, `bus_own`=0, `rw`=0, `rs`=0. Then go to IDLE.
- `req` asserted while `busy`=1 is ignored; it is not queued. A `req` in the DONE cycle is also ignored.
- `d_in` is not synchronized. By construction it is stable for ≥90 ns (tDDR 360 ns) before the sample edge.

## Timing
- Reset values: `busy`=0, `rsp_valid`=0, `rsp_timeout`=0, `rsp_data`=0x00, `bus_own`=0, `rs`=0, `rw`=0, `e`=0, state IDLE.
- Reset asserted mid-read: all outputs return to reset values asynchronously, E drops immediately, and no `rsp_valid` is issued.
- Single read latency: with `req` sampled at edge 0, `rsp_valid` is high in cycle 1+T_AS+T_PW+T_EL, which is 107 at the defaults.
- `e` rises at edge 1+T_AS and falls at edge 1+T_AS+T_PW. RS/RW change only while `e`=0.
- Poll: each extra status read adds T_AS+T_PW+T_EL cycles (106). The worst case is MAX_POLLS reads followed by `rsp_timeout`=1.
- BF clearing on the first read: `rsp_valid` arrives at the single-read latency with `rsp_timeout`=0.
- Back-to-back reads: the earliest next accepted `req` is the cycle after DONE.

## Structure
- Shared package `lcd_pkg` holds:
  - Timing constants as ns values plus a cycles-from-ns function on CLK_FREQ, shared with the writer.
  - `LCD_BF_BIT`=7 and the address-counter field [6:0].
  - The RS encodings (instruction/status 0, data 1).
- One sub-module, `lcd_strobe_timer`, is natural: the phase counter with load-length input and a `last` flag. It is reusable by the writer.

## Test plan
- Status read, `d_in`=0x25, `req_rs`=0 → `rs`=0, `rw`=1, `e` high for exactly 45 cycles, `rsp_valid` at cycle 107 with `rsp_data`=0x25 and `rsp_timeout`=0.
- Data read, `d_in`=0x48 → `rs`=1 throughout, `rsp_data`=0x48. `req_poll`=1 is ignored: only one strobe occurs.
- Poll, `d_in`=0x80 for 3 strobes then 0x07 → exactly 4 E pulses, `rsp_data`=0x07, `rsp_timeout`=0, `rsp_valid` at cycle 1+4·106.
- Poll with MAX_POLLS=4 and `d_in` held at 0xFF → 4 strobes, `rsp_valid` with `rsp_timeout`=1 and `rsp_data`=0xFF.
- `req` pulsed at cycles 50 and 107 during a read → no extra strobes and a single `rsp_valid`. A `req` at cycle 108 starts a new read.
- `reset_n` low while `e`=1 → `e`, `bus_own` and `busy` go to 0 asynchronously, no `rsp_valid`. After release, a fresh read completes normally.
